cbus_mem_responder: RTL and testbench

Responder end of the CBus: a synthesizable on-chip word memory that accepts `cbus_req_t` transactions (single beats and FIXED/INCR/WRAP bursts, byte-strobed writes) and answers with `cbus_resp_t`. It sits where the external memory/AXI bridge normally sits. Its uses are:
- terminating the data-side CBus in simulation and unit tests;
- backing a small scratchpad in the SoC model.

A configurable initial latency emulates slow memory.

---
 rtl/cbus_mem_responder_pkg.sv | 55 +++++
 rtl/cbus_mem_responder_array.sv | 31 +++
 rtl/cbus_mem_responder.sv | 124 ++++++++++++
 tb/tb_cbus_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_mem_responder_pkg.sv
// CBus request/response types shared by the memory responder and its array.
// Burst lengths are encoded as beats-1; WRAP only wraps for power-of-two lengths.
package cbus_mem_responder_pkg;

    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 64;
    localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

    typedef logic [3:0] mlen_t;

    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN3  = 4'd2;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN5  = 4'd4;
    localparam mlen_t MLEN6  = 4'd5;
    localparam mlen_t MLEN7  = 4'd6;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN9  = 4'd8;
    localparam mlen_t MLEN10 = 4'd9;
    localparam mlen_t MLEN11 = 4'd10;
    localparam mlen_t MLEN12 = 4'd11;
    localparam mlen_t MLEN13 = 4'd12;
    localparam mlen_t MLEN14 = 4'd13;
    localparam mlen_t MLEN15 = 4'd14;
    localparam mlen_t MLEN16 = 4'd15;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_type_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [2:0]             size;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
        mlen_t                  len;
        axi_burst_type_t        burst;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    function automatic logic wrap_len_legal(mlen_t len);
        return (len == MLEN2) || (len == MLEN4) || (len == MLEN8) || (len == MLEN16);
    endfunction

endpackage

// File: rtl/cbus_mem_responder_array.sv
// Word memory behind the responder: asynchronous read, byte-strobed synchronous
// write on a shared index, no reset so contents survive a responder reset.
module cbus_mem_array
    import cbus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    localparam int IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic                   clk,
    input  logic [IDX_W-1:0]       addr,
    input  logic                   we,
    input  logic [CBUS_STRB_W-1:0] wstrb,
    input  logic [CBUS_DATA_W-1:0] wdata,
    output logic [CBUS_DATA_W-1:0] rdata
);

    logic [CBUS_DATA_W-1:0] mem [MEM_WORDS];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < CBUS_STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus responder backed by a local word memory: latches a request in IDLE,
// waits LATENCY cycles, then streams FIXED/INCR/WRAP beats while valid holds.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx_q;
    mlen_t             len_q;
    mlen_t             beat_q;
    axi_burst_type_t   burst_q;
    logic              is_write_q;
    logic [LAT_W-1:0]  lat_q;

    logic                   beat;
    logic                   last_beat;
    logic [IDX_W-1:0]       wrap_mask;
    logic [IDX_W-1:0]       idx_inc;
    logic [IDX_W-1:0]       idx_nxt;
    logic [CBUS_DATA_W-1:0] rdata;
    logic                   unused_req;

    // A beat happens only in BURST with valid held; abort is simply valid low.
    assign beat      = (state == BURST) && creq.valid;
    assign last_beat = beat && (beat_q == len_q);

    assign unused_req = ^{creq.size, creq.addr[2:0], creq.addr[CBUS_ADDR_W-1:IDX_W+3]};

    // WRAP keeps the bits above the len mask and rolls the bits under it.
    always_comb begin
        wrap_mask = '0;
        if (burst_q == AXI_BURST_WRAP && wrap_len_legal(len_q)) begin
            wrap_mask = IDX_W'(len_q);
        end
        idx_inc = idx_q + IDX_W'(1);
        if (burst_q == AXI_BURST_FIXED) begin
            idx_nxt = idx_q;
        end else if (wrap_mask != '0) begin
            idx_nxt = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
        end else begin
            idx_nxt = idx_inc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx_q      <= '0;
            len_q      <= MLEN1;
            beat_q     <= '0;
            burst_q    <= AXI_BURST_FIXED;
            is_write_q <= 1'b0;
            lat_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (creq.valid) begin
                        idx_q      <= creq.addr[IDX_W+2:3];
                        len_q      <= creq.len;
                        burst_q    <= creq.burst;
                        is_write_q <= creq.is_write;
                        beat_q     <= '0;
                        lat_q      <= LAT_W'(LATENCY);
                        state      <= (LATENCY > 0) ? WAIT : BURST;
                    end
                end
                WAIT: begin
                    if (!creq.valid) begin
                        state <= IDLE;
                    end else if (lat_q <= LAT_W'(1)) begin
                        state <= BURST;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                BURST: begin
                    if (!creq.valid || beat_q == len_q) begin
                        state <= IDLE;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                        idx_q  <= idx_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cbus_mem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk  (clk),
        .addr (idx_q),
        .we   (beat && is_write_q),
        .wstrb(creq.strobe),
        .wdata(creq.data),
        .rdata(rdata)
    );

    always_comb begin
        cresp       = '0;
        cresp.ready = beat;
        cresp.last  = last_beat;
        cresp.data  = (beat && !is_write_q) ? rdata : '0;
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: a bench-side memory model and burst
// address arithmetic predict ready/last/data every cycle, plus literal spot checks.
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    logic [63:0] model [MEM_WORDS];
    logic [63:0] cap [16];
    logic        exp_ready = 1'b0;
    logic        exp_last = 1'b0;
    logic [63:0] exp_data = '0;
    int          n_vec = 0;
    int          n_err = 0;

    cbus_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .LATENCY  (LATENCY)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .creq  (creq),
        .cresp (cresp)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    // Word visited on beat k, from plain burst arithmetic.
    function automatic int seq_idx(input int start, input int nb, input axi_burst_type_t bt, input int k);
        int base;
        if (bt == AXI_BURST_FIXED) return start;
        if (bt == AXI_BURST_WRAP && (nb == 2 || nb == 4 || nb == 8 || nb == 16)) begin
            base = start - (start % nb);
            return base + ((start % nb) + k) % nb;
        end
        return (start + k) % MEM_WORDS;
    endfunction

    always @(negedge clk) begin
        check("ready", 64'(cresp.ready), 64'(exp_ready));
        check("last", 64'(cresp.last), 64'(exp_last));
        check("data", cresp.data, exp_data);
    end

    task automatic set_idle_exp();
        exp_ready = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
    endtask

    task automatic scramble(input bit wr);
        creq.addr     = $urandom;
        creq.len      = mlen_t'($urandom);
        creq.burst    = axi_burst_type_t'($urandom_range(0, 2));
        creq.is_write = ~wr;
        creq.size     = 3'($urandom);
        creq.strobe   = 8'($urandom);
        creq.data     = {$urandom, $urandom};
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            scramble(1'b0);
            creq.valid = 1'b0;
            set_idle_exp();
        end
    endtask

    task automatic txn(input bit wr, input int start, input int nb, input axi_burst_type_t bt,
                       input logic [7:0] strb, input logic [63:0] dbase, input int abort_at);
        int w0;
        int w;
        w0 = start % MEM_WORDS;
        @(posedge clk);
        #1;
        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.addr     = 32'(start * 8) | 32'd5;
        creq.size     = 3'd3;
        creq.len      = mlen_t'(nb - 1);
        creq.burst    = bt;
        set_idle_exp();
        for (int l = 0; l < LATENCY; l++) begin
            @(posedge clk);
            #1;
            scramble(wr);
            creq.valid = 1'b1;
            set_idle_exp();
        end
        for (int k = 0; k < nb; k++) begin
            @(posedge clk);
            #1;
            scramble(wr);
            if (k == abort_at) begin
                creq.valid = 1'b0;
                set_idle_exp();
                return;
            end
            creq.valid = 1'b1;
            w = seq_idx(w0, nb, bt, k);
            exp_ready = 1'b1;
            exp_last  = (k == nb - 1);
            if (wr) begin
                creq.strobe = strb;
                creq.data   = dbase + 64'(k);
                exp_data    = '0;
                for (int b = 0; b < 8; b++)
                    if (strb[b]) model[w][8*b +: 8] = creq.data[8*b +: 8];
            end else begin
                exp_data = model[w];
            end
            #2;
            cap[k] = cresp.data;
        end
    endtask

    initial begin
        creq       = '0;
        creq.valid = 1'b1;
        resetn     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(cresp.ready), 64'd0);
        check("reset_last", 64'(cresp.last), 64'd0);
        check("reset_data", cresp.data, 64'd0);
        creq.valid = 1'b0;
        #2;
        resetn = 1'b1;
        idle_cycles(2);

        // Model pins for the burst address arithmetic.
        check("seq_incr_3", 64'(seq_idx(6, 4, AXI_BURST_INCR, 3)), 64'd9);
        check("seq_wrap4_2", 64'(seq_idx(6, 4, AXI_BURST_WRAP, 2)), 64'd4);
        check("seq_wrap8_3", 64'(seq_idx(13, 8, AXI_BURST_WRAP, 3)), 64'd8);
        check("seq_wrap3_2", 64'(seq_idx(7, 3, AXI_BURST_WRAP, 2)), 64'd9);
        check("seq_incr_wrap", 64'(seq_idx(1023, 2, AXI_BURST_INCR, 1)), 64'd0);

        // Preload words 0..63 with F00D_..._w, back to back.
        for (int s = 0; s < 64; s += 16)
            txn(1'b1, s, 16, AXI_BURST_INCR, 8'hFF, 64'hF00D_0000_0000_0000 + 64'(s), -1);
        txn(1'b1, 1023, 1, AXI_BURST_INCR, 8'hFF, 64'h7777_0000_0000_0000, -1);
        txn(1'b1, 5, 1, AXI_BURST_INCR, 8'hFF, 64'hDEAD_BEEF_0123_4567, -1);
        txn(1'b1, 2, 1, AXI_BURST_INCR, 8'hFF, 64'h0, -1);
        idle_cycles(1);

        txn(1'b0, 5, 1, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("single_read", cap[0], 64'hDEAD_BEEF_0123_4567);

        txn(1'b1, 2, 1, AXI_BURST_INCR, 8'h0F, 64'h1111_2222_3333_4444, -1);
        txn(1'b0, 2, 1, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("strobed_write", cap[0], 64'h0000_0000_3333_4444);

        txn(1'b0, 6, 4, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("incr_beat2", cap[2], 64'hF00D_0000_0000_0008);
        txn(1'b0, 6, 4, AXI_BURST_WRAP, 8'h00, 64'h0, -1);
        check("wrap4_beat2", cap[2], 64'hF00D_0000_0000_0004);
        txn(1'b0, 13, 8, AXI_BURST_WRAP, 8'h00, 64'h0, -1);
        check("wrap8_beat3", cap[3], 64'hF00D_0000_0000_0008);
        txn(1'b0, 7, 3, AXI_BURST_WRAP, 8'h00, 64'h0, -1);
        check("wrap_odd_len", cap[2], 64'hF00D_0000_0000_0009);

        txn(1'b1, 20, 4, AXI_BURST_FIXED, 8'hFF, 64'hAB00_0000_0000_0000, -1);
        txn(1'b0, 20, 1, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("fixed_final", cap[0], 64'hAB00_0000_0000_0003);

        txn(1'b0, 1023, 2, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("incr_top_wrap", cap[1], 64'hF00D_0000_0000_0000);
        txn(1'b0, 1024 + 3, 1, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("alias_read", cap[0], 64'hF00D_0000_0000_0003);

        txn(1'b1, 24, 8, AXI_BURST_INCR, 8'hFF, 64'h5555_0000_0000_0000, 2);
        txn(1'b0, 24, 8, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("abort_written", cap[1], 64'h5555_0000_0000_0001);
        check("abort_untouched", cap[2], 64'hF00D_0000_0000_001A);
        idle_cycles(2);

        // Reset while the read is waiting out its latency.
        @(posedge clk);
        #1;
        creq = '0;
        creq.valid = 1'b1;
        creq.addr  = 32'h28;
        creq.len   = MLEN1;
        creq.burst = AXI_BURST_INCR;
        set_idle_exp();
        @(posedge clk);
        #1;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_wait_ready", 64'(cresp.ready), 64'd0);
        @(posedge clk);
        #1;
        creq.valid = 1'b0;
        #2;
        resetn = 1'b1;
        idle_cycles(5);

        // Reset landing in the second beat of a write: that beat is dropped.
        @(posedge clk);
        #1;
        creq = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.addr     = 32'(40 * 8);
        creq.len      = MLEN4;
        creq.burst    = AXI_BURST_INCR;
        for (int l = 0; l < LATENCY; l++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        creq.strobe = 8'hFF;
        creq.data   = 64'h4040_0000_0000_0000;
        exp_ready   = 1'b1;
        model[40]   = creq.data;
        @(posedge clk);
        #1;
        creq.data = 64'h4040_0000_0000_0001;
        set_idle_exp();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_burst_ready", 64'(cresp.ready), 64'd0);
        @(posedge clk);
        #1;
        creq.valid = 1'b0;
        #2;
        resetn = 1'b1;
        idle_cycles(3);
        txn(1'b0, 40, 2, AXI_BURST_INCR, 8'h00, 64'h0, -1);
        check("rst_beat0_kept", cap[0], 64'h4040_0000_0000_0000);
        check("rst_beat1_dropped", cap[1], 64'hF00D_0000_0000_0029);

        idle_cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
